multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Sequencing FSM for the multi-cycle RV32I core.
- Drives the shared ALU, one unified instruction/data memory port, the instruction register, the PC and the register file across several clock cycles per instruction.
- Decodes opcode/funct3/funct7 from the instruction register.
- Handles a variable-latency memory ready handshake and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- opcode  in  7  instruction register bits [6:0].
- funct3  in  3  instruction register bits [14:12].
- funct7  in  7  instruction register bits [31:25].
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU compare flags for rs1−rs2.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write when mem_req=1.
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  latch the fetched word into IR and PC into oldPC.
- pc_write  out  1  load PC from result mux.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  ALU A select: 0=PC, 1=oldPC, 2=rs1, 3=zero.
- alu_src_b  out  2  ALU B select: 0=rs2, 1=imm, 2=const 4.
- result_src  out  2  result mux select: 0=ALUOut, 1=mem data, 2=ALU result.
- alu_op  out  aluOperations  ALU operation.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- instret  out  CNT_W  retired-instruction count.
- illegal  out  1  sticky illegal-opcode flag.

## Operation
States: START, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, MEMADR, MEMRD, MEMWR, MEMWB, ALUWB, BRANCH, JALR_ADR, JUMP, TRAP.

- **START:** all outputs 0; next state FETCH.
- **FETCH:** mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, alu_op=ADD, result_src=2.
  - When mem_ready=1: ir_write=1 and pc_write=1 (PC becomes PC+4), go to DECODE.
  - Otherwise hold with ir_write=0 and pc_write=0.
- **DECODE:** alu_src_a=1, alu_src_b=1, ADD (oldPC+imm into ALUOut). Next state by opcode:
  - R → EXEC_R
  - I → EXEC_I
  - LOAD or STORE → MEMADR
  - BRANCH → BRANCH
  - JAL → JUMP
  - JALR → JALR_ADR
  - LUI or AUIPC → EXEC_U
  - anything else → TRAP
- **EXEC_R:** A=rs1, B=rs2, alu_op from the funct decoder; next ALUWB.
- **EXEC_I:** A=rs1, B=imm, alu_op from the funct decoder; next ALUWB.
  - For funct3 001/101, funct7 selects SLL/SRL/SRA.
  - For all other funct3, funct7 is ignored.
- **EXEC_U:** B=imm, ADD; A=zero for LUI, A=oldPC for AUIPC; next ALUWB.
- **ALUWB:** result_src=0, reg_write=1, retire=1; next FETCH.
- **MEMADR:** A=rs1, B=imm, ADD. Next MEMRD for LOAD, MEMWR for STORE.
- **MEMRD:** mem_req=1, adr_src=1. Hold until mem_ready=1, then go to MEMWB.
- **MEMWB:** result_src=1, reg_write=1, retire=1; next FETCH.
- **MEMWR:** mem_req=1, mem_we=1, adr_src=1. Hold until mem_ready=1; in that cycle retire=1; next FETCH.
- **BRANCH:** A=rs1, B=rs2, SUB, result_src=0, retire=1; next FETCH.
  - pc_write=1 when the branch is taken:
    - 000 BEQ: zero
    - 001 BNE: !zero
    - 100 BLT: lt
    - 101 BGE: !lt
    - 110 BLTU: ltu
    - 111 BGEU: !ltu
  - funct3 010/011: not taken.
- **JALR_ADR:** A=rs1, B=imm, ADD; next JUMP.
- **JUMP:** pc_write=1, result_src=0, A=oldPC, B=4, ADD (link value into ALUOut); next ALUWB.
- **TRAP:** illegal=1, all other outputs 0; remains in TRAP until reset.

Funct decoder mapping (R and I): ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU. An undefined funct7 combination falls back to ADD.

instret:
- Increments by 1 on every clock edge where retire=1.
- Wraps from all-ones to 0.

## Timing
- Outputs are combinational from state; mem_ready and the branch flags gate outputs in the same cycle (Mealy). All registered state is updated on the rising clk edge.
- Reset (rst_n=0) asynchronously forces START, instret=0 and illegal=0, so every output is 0 while reset is held.
  - Reset mid-transaction abandons it; mem_req drops immediately.
  - First FETCH is the second edge after release.
- Cycles per instruction with mem_ready=1 on request:
  - R/I/LUI/AUIPC/STORE/JAL: 4
  - LOAD/JALR: 5
  - BRANCH: 3
- Each memory wait cycle adds 1 cycle.
- mem_req stays high and address/we stay stable from first assertion until the mem_ready cycle.
- mem_ready is ignored when mem_req=0.

## Structure
- Shared package (typedef.svh) holds:
  - state enum
  - alu_src_a, alu_src_b and result_src select constants
  - existing opcode constants and aluOperations
- One sub-module, multicycle_alu_dec: funct3/funct7/opcode → alu_op, purely combinational.
- The FSM, branch-condition logic and counter live in multicycle_ctrl.

## Test plan
- **Reset then ADD (R, 000/0000000), mem_ready tied 1:** after reset release, START→FETCH→DECODE→EXEC_R→ALUWB; reg_write=1 only in ALUWB; retire pulses once; instret=1.
- **LW with mem_ready delayed 3 cycles in MEMRD:** mem_req stays 1 with adr_src=1 for 4 cycles; MEMWB follows the ready cycle; total 8 cycles.
- **BEQ, alu_zero=1 vs 0:** pc_write=1 in BRANCH for the first case and 0 for the second; both take 3 cycles.
- **JALR:** JALR_ADR then JUMP (pc_write=1, result_src=0) then ALUWB (reg_write=1); 5 cycles.
- **SRAI (I, 101/0100000) → SRA; XORI with funct7=7'h7F → XOR; opcode 7'h7F → TRAP:** illegal=1 and held, with no further mem_req until rst_n is pulsed.
- **rst_n asserted mid-MEMWR with CNT_W=4, instret preloaded to 15 via 15 retires:**
  - 16th retire wraps instret to 0.
  - rst_n low drops mem_req and mem_we the same cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path:
// FSM states, ALU operations, datapath select codes and opcodes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    START, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, MEMADR, MEMRD,
    MEMWR, MEMWB, ALUWB, BRANCH, JALR_ADR, JUMP, TRAP
  } ctrlState;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluOperations;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;
  localparam logic [1:0] SRC_A_ZERO  = 2'd3;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_MEMDATA   = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/multicycle_alu_dec.sv
// Combinational funct3/funct7 decoder for R- and I-type ALU instructions.
// Any funct7 pattern the ISA does not define falls back to ADD.
module multicycle_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  output aluOperations alu_op_o
);

  logic rType;
  logic f7Base;

  assign rType  = (opcode_i == OP_R);
  // I-type immediates reuse funct7 bits, so only R-type must see a clean funct7
  assign f7Base = !rType || (funct7_i == F7_BASE);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (funct3_i)
      3'b000: if (rType && funct7_i == F7_ALT) alu_op_o = ALU_SUB;
      3'b001: if (funct7_i == F7_BASE) alu_op_o = ALU_SLL;
      3'b101: begin
        if (funct7_i == F7_BASE)     alu_op_o = ALU_SRL;
        else if (funct7_i == F7_ALT) alu_op_o = ALU_SRA;
      end
      3'b010: if (f7Base) alu_op_o = ALU_SLT;
      3'b011: if (f7Base) alu_op_o = ALU_SLTU;
      3'b100: if (f7Base) alu_op_o = ALU_XOR;
      3'b110: if (f7Base) alu_op_o = ALU_OR;
      3'b111: if (f7Base) alu_op_o = ALU_AND;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32I core: memory handshake,
// branch resolution, retired-instruction counter and sticky illegal flag.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output aluOperations     alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  ctrlState         state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  aluOperations     decAluOp;
  logic             branchTaken;

  multicycle_alu_dec u_alu_dec (
    .opcode_i (opcode),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .alu_op_o (decAluOp)
  );

  always_comb begin
    case (funct3)
      3'b000:  branchTaken = alu_zero;
      3'b001:  branchTaken = !alu_zero;
      3'b100:  branchTaken = alu_lt;
      3'b101:  branchTaken = !alu_lt;
      3'b110:  branchTaken = alu_ltu;
      3'b111:  branchTaken = !alu_ltu;
      default: branchTaken = 1'b0;
    endcase
  end

  // Mealy outputs: mem_ready and branch flags act within the same cycle
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;
    retire     = 1'b0;
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JUMP;
          OP_JALR:           state_d = JALR_ADR;
          OP_LUI, OP_AUIPC:  state_d = EXEC_U;
          default:           state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = decAluOp;
        state_d   = ALUWB;
      end
      EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = decAluOp;
        state_d   = ALUWB;
      end
      EXEC_U: begin
        alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_STORE) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_SUB;
        pc_write  = branchTaken;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JALR_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = JUMP;
      end
      JUMP: begin
        pc_write  = 1'b1;
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        state_d   = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= START;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_d == TRAP) illegal_q <= 1'b1;
    end
  end

  assign instret = instret_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random-instruction bench for multicycle_ctrl: each instruction is expanded
// into its expected per-cycle output trace and compared cycle by cycle.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode = '0;
  logic [2:0]       funct3 = '0;
  logic [6:0]       funct7 = '0;
  logic             alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, result_src;
  aluOperations     alu_op;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             illegal;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .retire(retire), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             memReq, memWe, adrSrc, irWrite, pcWrite, regWrite;
    logic [1:0]       srcA, srcB, resSrc;
    logic [3:0]       aluOp;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic             illegal;
  } outs_t;

  outs_t            expQ[$];
  int               checks = 0;
  int               errors = 0;
  int               cycleNo = 0;
  logic [CNT_W-1:0] modelCnt = '0;
  logic             modelIll = 1'b0;
  int               stepIdx = 0;
  logic             snapPcWrite [32];
  logic [3:0]       snapAluOp [32];
  logic [6:0]       ops [9];

  function automatic outs_t mk(input logic memReq, memWe, adrSrc, irWrite, pcWrite,
                               regWrite, input logic [1:0] srcA, srcB, resSrc,
                               input logic [3:0] aluOp, input logic ret);
    outs_t e;
    e = '0;
    e.memReq = memReq;  e.memWe = memWe;  e.adrSrc = adrSrc;
    e.irWrite = irWrite; e.pcWrite = pcWrite; e.regWrite = regWrite;
    e.srcA = srcA; e.srcB = srcB; e.resSrc = resSrc;
    e.aluOp = aluOp; e.retire = ret;
    return e;
  endfunction

  function automatic outs_t dutOuts();
    outs_t o;
    o.memReq = mem_req;  o.memWe = mem_we;  o.adrSrc = adr_src;
    o.irWrite = ir_write; o.pcWrite = pc_write; o.regWrite = reg_write;
    o.srcA = alu_src_a; o.srcB = alu_src_b; o.resSrc = result_src;
    o.aluOp = alu_op; o.retire = retire; o.instret = instret; o.illegal = illegal;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Operation table for R/I: R-type demands funct7 0 except SUB/SRA; bad combos mean ADD
  function automatic logic [3:0] expAlu(input logic isR, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [3:0] base [8];
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (f3 == 3'd0) return (isR && f7 == 7'h20) ? ALU_SUB : ALU_ADD;
    if (f3 == 3'd5) return (f7 == 7'h00) ? ALU_SRL : (f7 == 7'h20) ? ALU_SRA : ALU_ADD;
    if (f3 == 3'd1) return (f7 == 7'h00) ? ALU_SLL : ALU_ADD;
    if (isR && f7 != 7'h00) return ALU_ADD;
    return base[f3];
  endfunction

  function automatic logic expTaken(input logic [2:0] f3, input logic z, lt, ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      outs_t e;
      e = expQ.pop_front();
      checkOutput($sformatf("outs_cyc%0d", cycleNo), dutOuts(), e);
    end
    cycleNo++;
  end

  // One clock of stimulus: entered and left 2 time units after a rising edge
  task automatic applyStimulus(input outs_t e, input logic rdy, z, lt, ltu);
    mem_ready = rdy; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
    e.instret = modelCnt;
    e.illegal = modelIll;
    expQ.push_back(e);
    if (e.retire) modelCnt++;
    #1;
    if (stepIdx < 32) begin
      snapPcWrite[stepIdx] = pc_write;
      snapAluOp[stepIdx]   = alu_op;
    end
    stepIdx++;
    @(posedge clk); #2;
  endtask

  task automatic applyReset(input int n);
    rst_n = 1'b0;
    modelCnt = '0;
    modelIll = 1'b0;
    repeat (n) begin
      mem_ready = rb();
      expQ.push_back('0);
      @(posedge clk); #2;
    end
    rst_n = 1'b1;
    expQ.push_back('0);
    @(posedge clk); #2;
  endtask

  task automatic doInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int fWaits, input int mWaits, input logic z, lt, ltu);
    outs_t wb;
    wb = mk(0, 0, 0, 0, 0, 1, SRC_A_PC, SRC_B_RS2, RES_ALUOUT, ALU_ADD, 1);
    stepIdx = 0;
    opcode = op; funct3 = f3; funct7 = f7;
    repeat (fWaits)
      applyStimulus(mk(1, 0, 0, 0, 0, 0, SRC_A_PC, SRC_B_FOUR, RES_ALURESULT, ALU_ADD, 0),
                    0, rb(), rb(), rb());
    applyStimulus(mk(1, 0, 0, 1, 1, 0, SRC_A_PC, SRC_B_FOUR, RES_ALURESULT, ALU_ADD, 0),
                  1, rb(), rb(), rb());
    applyStimulus(mk(0, 0, 0, 0, 0, 0, SRC_A_OLDPC, SRC_B_IMM, RES_ALUOUT, ALU_ADD, 0),
                  rb(), rb(), rb(), rb());
    case (op)
      OP_R, OP_I: begin
        applyStimulus(mk(0, 0, 0, 0, 0, 0, SRC_A_RS1, (op == OP_I) ? SRC_B_IMM : SRC_B_RS2,
                         RES_ALUOUT, expAlu(op == OP_R, f3, f7), 0), rb(), rb(), rb(), rb());
        applyStimulus(wb, rb(), rb(), rb(), rb());
      end
      OP_LUI, OP_AUIPC: begin
        applyStimulus(mk(0, 0, 0, 0, 0, 0, (op == OP_LUI) ? SRC_A_ZERO : SRC_A_OLDPC,
                         SRC_B_IMM, RES_ALUOUT, ALU_ADD, 0), rb(), rb(), rb(), rb());
        applyStimulus(wb, rb(), rb(), rb(), rb());
      end
      OP_LOAD, OP_STORE: begin
        logic st;
        st = (op == OP_STORE);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, SRC_A_RS1, SRC_B_IMM, RES_ALUOUT, ALU_ADD, 0),
                      rb(), rb(), rb(), rb());
        repeat (mWaits)
          applyStimulus(mk(1, st, 1, 0, 0, 0, 0, 0, 0, ALU_ADD, 0), 0, rb(), rb(), rb());
        applyStimulus(mk(1, st, 1, 0, 0, 0, 0, 0, 0, ALU_ADD, st), 1, rb(), rb(), rb());
        if (!st)
          applyStimulus(mk(0, 0, 0, 0, 0, 1, SRC_A_PC, SRC_B_RS2, RES_MEMDATA, ALU_ADD, 1),
                        rb(), rb(), rb(), rb());
      end
      OP_BRANCH:
        applyStimulus(mk(0, 0, 0, 0, expTaken(f3, z, lt, ltu), 0, SRC_A_RS1, SRC_B_RS2,
                         RES_ALUOUT, ALU_SUB, 1), rb(), z, lt, ltu);
      OP_JAL, OP_JALR: begin
        if (op == OP_JALR)
          applyStimulus(mk(0, 0, 0, 0, 0, 0, SRC_A_RS1, SRC_B_IMM, RES_ALUOUT, ALU_ADD, 0),
                        rb(), rb(), rb(), rb());
        applyStimulus(mk(0, 0, 0, 0, 1, 0, SRC_A_OLDPC, SRC_B_FOUR, RES_ALUOUT, ALU_ADD, 0),
                      rb(), rb(), rb(), rb());
        applyStimulus(wb, rb(), rb(), rb(), rb());
      end
      default: begin
        modelIll = 1'b1;
        repeat (6) applyStimulus('0, rb(), rb(), rb(), rb());
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    @(posedge clk); #2;
    applyReset(2);

    doInstr(OP_R, 3'b000, 7'h00, 0, 0, 0, 0, 0);
    checkOutput("add_instret", 64'(instret), 64'd1);
    checkOutput("add_cycles", 64'(stepIdx), 64'd4);

    doInstr(OP_LOAD, 3'b010, 7'h00, 0, 3, 0, 0, 0);
    checkOutput("lw_wait3_cycles", 64'(stepIdx), 64'd8);

    doInstr(OP_BRANCH, 3'b000, 7'h00, 0, 0, 1, 0, 0);
    checkOutput("beq_taken_pcwrite", 64'(snapPcWrite[2]), 64'd1);
    checkOutput("beq_taken_cycles", 64'(stepIdx), 64'd3);
    doInstr(OP_BRANCH, 3'b000, 7'h00, 0, 0, 0, 1, 1);
    checkOutput("beq_not_taken_pcwrite", 64'(snapPcWrite[2]), 64'd0);
    checkOutput("beq_not_taken_cycles", 64'(stepIdx), 64'd3);

    doInstr(OP_JALR, 3'b000, 7'h00, 0, 0, 0, 0, 0);
    checkOutput("jalr_jump_pcwrite", 64'(snapPcWrite[3]), 64'd1);
    checkOutput("jalr_cycles", 64'(stepIdx), 64'd5);

    doInstr(OP_I, 3'b101, 7'h20, 0, 0, 0, 0, 0);
    checkOutput("srai_aluop", 64'(snapAluOp[2]), 64'(ALU_SRA));
    doInstr(OP_I, 3'b100, 7'h7F, 0, 0, 0, 0, 0);
    checkOutput("xori_f7ff_aluop", 64'(snapAluOp[2]), 64'(ALU_XOR));

    for (int n = 0; n < 250; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      int         sel;
      op  = ops[$urandom_range(0, 8)];
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 3);
      f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom_range(0, 127));
      doInstr(op, f3, f7, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
              $urandom_range(0, 3), rb(), rb(), rb());
    end

    applyReset(1);
    checkOutput("reset_instret", 64'(instret), 64'd0);
    repeat (15) doInstr(OP_R, 3'($urandom_range(0, 7)), 7'h00, 0, 0, 0, 0, 0);
    checkOutput("instret_15", 64'(instret), 64'd15);
    doInstr(OP_I, 3'b000, 7'h00, 0, 0, 0, 0, 0);
    checkOutput("instret_wrap", 64'(instret), 64'd0);

    // Store stalled in MEMWR, then reset lands while the request is open
    stepIdx = 0;
    opcode = OP_STORE; funct3 = 3'b010; funct7 = 7'h00;
    applyStimulus(mk(1, 0, 0, 1, 1, 0, SRC_A_PC, SRC_B_FOUR, RES_ALURESULT, ALU_ADD, 0),
                  1, 0, 0, 0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, SRC_A_OLDPC, SRC_B_IMM, RES_ALUOUT, ALU_ADD, 0),
                  0, 0, 0, 0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, SRC_A_RS1, SRC_B_IMM, RES_ALUOUT, ALU_ADD, 0),
                  0, 0, 0, 0);
    repeat (2) applyStimulus(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, ALU_ADD, 0), 0, 0, 0, 0);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    checkOutput("reset_drops_memreq", 64'(mem_req), 64'd0);
    checkOutput("reset_drops_memwe", 64'(mem_we), 64'd0);
    modelCnt = '0;
    expQ.push_back('0);
    @(posedge clk); #2;
    applyReset(1);
    checkOutput("reset_mid_store_instret", 64'(instret), 64'd0);

    doInstr(7'h7F, 3'b000, 7'h00, 0, 0, 0, 0, 0);
    checkOutput("trap_illegal", 64'(illegal), 64'd1);
    applyReset(1);
    checkOutput("illegal_cleared", 64'(illegal), 64'd0);
    doInstr(OP_R, 3'b000, 7'h20, 1, 0, 0, 0, 0);
    checkOutput("recovered_instret", 64'(instret), 64'd1);

    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
